// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types for the intersection phase controller.
// Holds the phase state codes and the one-hot light encodings.
package tlc_pkg;

    typedef enum logic [2:0] {
        NS_G   = 3'd0,
        NS_Y   = 3'd1,
        ALL_R1 = 3'd2,
        EW_G   = 3'd3,
        EW_Y   = 3'd4,
        ALL_R2 = 3'd5,
        PED    = 3'd6,
        EMERG  = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: W-bit phase down-counter with load.
// Ports: clk, rst (async, active-high), load, load_val in;
//        expired out (count is zero). Count holds at zero.
module tlc_phase_timer #(
    parameter int             W       = 5,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    // The FSM derives its load from the next state, which itself
    // depends on expiry, so expiry is taken from the count alone to
    // keep that path free of a combinational loop.
    assign expired = (cnt == '0);

endmodule

// File: rtl/tlc_ctrl.sv
// tlc_ctrl: two-road traffic light phase controller with ped/emergency.
// Ports: clk, rst (async, active-high), ped_req, emerg in;
//        ns_light, ew_light, ped_walk, phase, cycle_done out.
module tlc_ctrl
    import tlc_pkg::*;
#(
    parameter int W      = 5,
    parameter int T_NS_G = 20,
    parameter int T_EW_G = 16,
    parameter int T_Y    = 4,
    parameter int T_AR   = 2,
    parameter int T_PED  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic       cycle_done
);

    state_t       state;
    state_t       state_nxt;
    logic         ped_pend;
    logic         tmr_exp;
    logic         tmr_load;
    logic [W-1:0] tmr_val;

    function automatic logic [W-1:0] dur_m1(input state_t s);
        case (s)
            NS_G:          dur_m1 = W'(T_NS_G - 1);
            EW_G:          dur_m1 = W'(T_EW_G - 1);
            NS_Y, EW_Y:    dur_m1 = W'(T_Y - 1);
            ALL_R1, ALL_R2: dur_m1 = W'(T_AR - 1);
            PED:           dur_m1 = W'(T_PED - 1);
            default:       dur_m1 = '0;
        endcase
    endfunction

    tlc_phase_timer #(
        .W       (W),
        .RST_VAL (W'(T_AR - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ALL_R2;
        end else begin
            state <= state_nxt;
        end
    end

    // Emergency wins over any expiry; EMERG ignores the timer.
    always_comb begin
        state_nxt = state;
        if (emerg) begin
            if (state != EMERG) state_nxt = EMERG;
        end else if (state == EMERG) begin
            state_nxt = ALL_R2;
        end else if (tmr_exp) begin
            case (state)
                NS_G:    state_nxt = NS_Y;
                NS_Y:    state_nxt = ALL_R1;
                ALL_R1:  state_nxt = EW_G;
                EW_G:    state_nxt = EW_Y;
                EW_Y:    state_nxt = ALL_R2;
                ALL_R2:  state_nxt = ped_pend ? PED : NS_G;
                PED:     state_nxt = NS_G;
                default: state_nxt = state;
            endcase
        end
    end

    assign tmr_load = (state_nxt != state);
    assign tmr_val  = dur_m1(state_nxt);

    // A request is only consumed by a PED phase that runs to the end;
    // an emergency abort leaves it pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pend   <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            if (state == PED && tmr_exp && !emerg) begin
                ped_pend <= 1'b0;
            end else if (ped_req && state != PED) begin
                ped_pend <= 1'b1;
            end
            cycle_done <= (state == ALL_R2) && (state_nxt == NS_G);
        end
    end

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        case (state)
            NS_G:    ns_light = GRN;
            NS_Y:    ns_light = YEL;
            EW_G:    ew_light = GRN;
            EW_Y:    ew_light = YEL;
            default: ;
        endcase
    end

    assign ped_walk = (state == PED);
    assign phase    = state;

endmodule

// File: tb/tb_tlc_ctrl.sv
// tb_tlc_ctrl: randomized + directed bench for tlc_ctrl against a
// phase/age reference model; a second instance uses T_Y=T_AR=1.
module tb_tlc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ped_req;
    logic       emerg;
    logic [2:0] ns_a, ew_a, ph_a, ns_b, ew_b, ph_b;
    logic       walk_a, cd_a, walk_b, cd_b;

    always #5 clk = ~clk;

    tlc_ctrl dut_a (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .emerg      (emerg),
        .ns_light   (ns_a),
        .ew_light   (ew_a),
        .ped_walk   (walk_a),
        .phase      (ph_a),
        .cycle_done (cd_a)
    );

    tlc_ctrl #(.T_Y(1), .T_AR(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .emerg      (emerg),
        .ns_light   (ns_b),
        .ew_light   (ew_b),
        .ped_walk   (walk_b),
        .phase      (ph_b),
        .cycle_done (cd_b)
    );

    int n_chk = 0;
    int n_err = 0;

    // Durations indexed by phase code; EMERG has no duration.
    int dur_a[8] = '{20, 4, 2, 16, 4, 2, 10, 1};
    int dur_b[8] = '{20, 1, 1, 16, 1, 1, 10, 1};

    int mph_a, mage_a, mph_b, mage_b;
    bit mpend_a, mcd_a, mpend_b, mcd_b;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ns_of(input int ph);
        if (ph == 0) return 3'b001;
        if (ph == 1) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] ew_of(input int ph);
        if (ph == 3) return 3'b001;
        if (ph == 4) return 3'b010;
        return 3'b100;
    endfunction

    task automatic model(input int d[8], input bit pr, input bit em,
                         inout int ph, inout int age,
                         inout bit pend, inout bit cd);
        int nph;
        bit expire;
        expire = (ph != 7) && (age + 1 >= d[ph]);
        nph = ph;
        if (em) nph = 7;
        else if (ph == 7) nph = 5;
        else if (expire) begin
            if (ph == 5) nph = pend ? 6 : 0;
            else if (ph == 6) nph = 0;
            else nph = ph + 1;
        end
        cd = (ph == 5) && (nph == 0);
        if (ph == 6 && expire && !em) pend = 1'b0;
        else if (pr && ph != 6) pend = 1'b1;
        age = (nph != ph) ? 0 : age + 1;
        ph = nph;
    endtask

    task automatic model_reset();
        mph_a = 5; mage_a = 0; mpend_a = 0; mcd_a = 0;
        mph_b = 5; mage_b = 0; mpend_b = 0; mcd_b = 0;
    endtask

    task automatic check_all();
        check("a.phase", ph_a, mph_a);
        check("a.ns", ns_a, ns_of(mph_a));
        check("a.ew", ew_a, ew_of(mph_a));
        check("a.walk", walk_a, mph_a == 6);
        check("a.cd", cd_a, mcd_a);
        check("a.overlap", (ns_a != 3'b100) && (ew_a != 3'b100), 0);
        check("b.phase", ph_b, mph_b);
        check("b.ns", ns_b, ns_of(mph_b));
        check("b.ew", ew_b, ew_of(mph_b));
        check("b.walk", walk_b, mph_b == 6);
        check("b.cd", cd_b, mcd_b);
        check("b.overlap", (ns_b != 3'b100) && (ew_b != 3'b100), 0);
    endtask

    task automatic step(input bit pr, input bit em);
        ped_req = pr;
        emerg   = em;
        @(posedge clk);
        model(dur_a, pr, em, mph_a, mage_a, mpend_a, mcd_a);
        model(dur_b, pr, em, mph_b, mage_b, mpend_b, mcd_b);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_ph(input int ph, input string tag);
        int n;
        n = 0;
        while (ph_a != 3'(ph) && n < 200) begin
            step(0, 0);
            n++;
        end
        check(tag, ph_a, ph);
    endtask

    task automatic run_len(input int ph, output int n);
        n = 0;
        while (ph_a == 3'(ph) && n < 64) begin
            n++;
            step(0, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            assert (!((ns_a != 3'b100) && (ew_a != 3'b100)))
                else $error("lights overlap on instance a");
            assert (!((ns_b != 3'b100) && (ew_b != 3'b100)))
                else $error("lights overlap on instance b");
        end
    end

    initial begin
        int q[$];
        int n;
        int walks;
        bit em;

        rst = 1'b1;
        ped_req = 1'b0;
        emerg = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Free run: cycle_done in cycles 3 and 51.
        for (int k = 1; k <= 50; k++) begin
            step(0, 0);
            if (cd_a) q.push_back(k + 1);
        end
        check("cd_count", q.size(), 2);
        check("cd_first", (q.size() > 0) ? q[0] : 0, 3);
        check("cd_second", (q.size() > 1) ? q[1] : 0, 51);

        // Pedestrian pulse during EW_G.
        wait_ph(3, "wait_ew_g");
        step(1, 0);
        wait_ph(6, "wait_ped");
        run_len(6, n);
        check("ped_len", n, 10);
        check("ped_to_ns", ph_a, 0);
        check("ped_no_cd", cd_a, 0);
        walks = 0;
        for (int k = 0; k < 48; k++) begin
            step(0, 0);
            if (walk_a) walks++;
        end
        check("ped_once", walks, 0);

        // Emergency in NS_G cycle 5.
        wait_ph(0, "wait_ns_g");
        repeat (4) step(0, 0);
        step(0, 1);
        check("emerg_enter", ph_a, 7);
        repeat (6) step(0, 1);
        check("emerg_hold", ph_a, 7);
        step(0, 0);
        run_len(5, n);
        check("emerg_ar2", n, 2);
        run_len(0, n);
        check("emerg_nsg", n, 20);

        // Emergency on the last NS_Y cycle.
        wait_ph(1, "wait_ns_y");
        repeat (3) step(0, 0);
        step(0, 1);
        check("ny_emerg", ph_a, 7);
        step(0, 0);

        // Emergency aborting PED: PED is served again in full.
        step(1, 0);
        wait_ph(6, "wait_ped2");
        repeat (3) step(0, 0);
        step(0, 1);
        check("ped_abort", ph_a, 7);
        step(0, 0);
        run_len(5, n);
        check("abort_ar2", n, 2);
        run_len(6, n);
        check("ped_reserve", n, 10);

        // Asynchronous reset mid EW_G with a pending request.
        wait_ph(3, "wait_ew_g2");
        step(1, 0);
        repeat (3) step(0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_ph", ph_a, 5);
        check("rst_ns", ns_a, 3'b100);
        check("rst_ew", ew_a, 3'b100);
        check("rst_walk", walk_a, 0);
        check("rst_cd", cd_a, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
        walks = 0;
        for (int k = 0; k < 60; k++) begin
            step(0, 0);
            if (walk_a) walks++;
        end
        check("rst_no_ped", walks, 0);

        // Random traffic.
        em = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (em) em = ($urandom_range(3) != 0);
            else em = ($urandom_range(63) == 0);
            step($urandom_range(15) == 0, em);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
